// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small write FIFO with configurable framing
module uart_tx_fifo #(
    parameter int CLOCK_PER_BIT = 434,
    parameter int DATAWIDTH_BUS = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_ADDR     = 2,
    parameter int STATE_SIZE    = 3
) (
    input  logic                     UART_TX_FIFO_CLOCK_50,
    input  logic                     UART_TX_FIFO_RESET_InLow,
    input  logic                     UART_TX_FIFO_newData_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] UART_TX_FIFO_data_In,
    input  logic                     UART_TX_FIFO_LOCK_InHigh,
    output logic                     UART_TX_FIFO_tx_Out,
    output logic                     UART_TX_FIFO_busy_Out,
    output logic                     UART_TX_FIFO_full_Out,
    output logic                     UART_TX_FIFO_empty_Out,
    output logic [FIFO_ADDR:0]       UART_TX_FIFO_level_Out,
    output logic                     UART_TX_FIFO_overflow_Out
);

    localparam int DEPTH  = 1 << FIFO_ADDR;
    localparam int BAUD_W = (CLOCK_PER_BIT > 1) ? $clog2(CLOCK_PER_BIT) : 1;
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLOCK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATAWIDTH_BUS - 1);
    localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [FIFO_ADDR:0] LEVEL_FULL = (FIFO_ADDR + 1)'(DEPTH);

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic                     clk;
    logic                     rst_n;
    logic [DATAWIDTH_BUS-1:0] mem [DEPTH];
    logic [FIFO_ADDR-1:0]     wr_ptr;
    logic [FIFO_ADDR-1:0]     rd_ptr;
    logic [FIFO_ADDR:0]       level;
    logic                     overflow;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic [DATAWIDTH_BUS-1:0] head;
    logic                     head_parity;
    logic                     can_start;
    logic                     bit_done;

    state_t                   state;
    state_t                   state_next;
    logic [BAUD_W-1:0]        baud_cnt;
    logic [BAUD_W-1:0]        baud_next;
    logic [BIT_W-1:0]         bit_cnt;
    logic [BIT_W-1:0]         bit_next;
    logic [DATAWIDTH_BUS-1:0] shift;
    logic [DATAWIDTH_BUS-1:0] shift_next;
    logic                     parity_bit;
    logic                     parity_next;
    logic                     tx_reg;
    logic                     tx_next;

    assign clk   = UART_TX_FIFO_CLOCK_50;
    assign rst_n = UART_TX_FIFO_RESET_InLow;

    // Occupancy is the single source of truth for full/empty; pointers just wrap.
    assign full        = (level == LEVEL_FULL);
    assign empty       = (level == '0);
    assign push        = UART_TX_FIFO_newData_InHigh && !full;
    assign head        = mem[rd_ptr];
    assign head_parity = (^head) ^ (PARITY_MODE == 2);
    assign can_start   = !empty && !UART_TX_FIFO_LOCK_InHigh;
    assign bit_done    = (baud_cnt == BAUD_LAST);

    // FIFO storage needs no reset: discarded entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= UART_TX_FIFO_data_In;
        end
    end

    // FIFO pointers, occupancy and the sticky dropped-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_ADDR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_ADDR'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (FIFO_ADDR + 1)'(1);
                2'b01:   level <= level - (FIFO_ADDR + 1)'(1);
                default: level <= level;
            endcase
            if (UART_TX_FIFO_newData_InHigh && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmitter state, bit timing and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift      <= shift_next;
            parity_bit <= parity_next;
            tx_reg     <= tx_next;
        end
    end

    // Next-state logic: tx_next is the line value for the bit period that starts on this edge.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift;
        parity_next = parity_bit;
        tx_next     = tx_reg;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                baud_next = '0;
                bit_next  = '0;
                if (can_start) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    parity_next = head_parity;
                    state_next  = START;
                    tx_next     = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                    shift_next = {1'b0, shift[DATAWIDTH_BUS-1:1]};
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_next = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY_MODE != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        tx_next    = shift[0];
                        shift_next = {1'b0, shift[DATAWIDTH_BUS-1:1]};
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            PARITY: begin
                if (bit_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    baud_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_next = '0;
                        // Chain straight into the next frame so queued words leave without a gap.
                        if (can_start) begin
                            pop         = 1'b1;
                            shift_next  = head;
                            parity_next = head_parity;
                            state_next  = START;
                            tx_next     = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                baud_next  = '0;
                bit_next   = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign UART_TX_FIFO_tx_Out       = tx_reg;
    assign UART_TX_FIFO_busy_Out     = (state != IDLE);
    assign UART_TX_FIFO_full_Out     = full;
    assign UART_TX_FIFO_empty_Out    = empty;
    assign UART_TX_FIFO_level_Out    = level;
    assign UART_TX_FIFO_overflow_Out = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int W_A = 8, P_A = 0, S_A = 1;
    localparam int W_B = 9, P_B = 2, S_B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       newdata [2];
    logic       lock [2];
    logic [8:0] data_in [2];
    logic       tx [2];
    logic       busy [2];
    logic       full [2];
    logic       empty [2];
    logic       overflow [2];
    logic [2:0] level [2];

    int checks = 0;
    int passed = 0;

    logic [8:0] mq0 [$];
    logic [8:0] mq1 [$];
    logic       mov [2];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(W_A), .PARITY_MODE(P_A),
        .STOP_BITS(S_A), .FIFO_ADDR(2), .STATE_SIZE(3)
    ) dut_a (
        .UART_TX_FIFO_CLOCK_50      (clk),
        .UART_TX_FIFO_RESET_InLow   (rst_n),
        .UART_TX_FIFO_newData_InHigh(newdata[0]),
        .UART_TX_FIFO_data_In       (data_in[0][7:0]),
        .UART_TX_FIFO_LOCK_InHigh   (lock[0]),
        .UART_TX_FIFO_tx_Out        (tx[0]),
        .UART_TX_FIFO_busy_Out      (busy[0]),
        .UART_TX_FIFO_full_Out      (full[0]),
        .UART_TX_FIFO_empty_Out     (empty[0]),
        .UART_TX_FIFO_level_Out     (level[0]),
        .UART_TX_FIFO_overflow_Out  (overflow[0])
    );

    uart_tx_fifo #(
        .CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(W_B), .PARITY_MODE(P_B),
        .STOP_BITS(S_B), .FIFO_ADDR(2), .STATE_SIZE(3)
    ) dut_b (
        .UART_TX_FIFO_CLOCK_50      (clk),
        .UART_TX_FIFO_RESET_InLow   (rst_n),
        .UART_TX_FIFO_newData_InHigh(newdata[1]),
        .UART_TX_FIFO_data_In       (data_in[1]),
        .UART_TX_FIFO_LOCK_InHigh   (lock[1]),
        .UART_TX_FIFO_tx_Out        (tx[1]),
        .UART_TX_FIFO_busy_Out      (busy[1]),
        .UART_TX_FIFO_full_Out      (full[1]),
        .UART_TX_FIFO_empty_Out     (empty[1]),
        .UART_TX_FIFO_level_Out     (level[1]),
        .UART_TX_FIFO_overflow_Out  (overflow[1])
    );

    function automatic int width_of(input int d);
        return (d == 0) ? W_A : W_B;
    endfunction

    function automatic int frame_bits(input int d);
        if (d == 0) return 1 + W_A + ((P_A != 0) ? 1 : 0) + S_A;
        return 1 + W_B + ((P_B != 0) ? 1 : 0) + S_B;
    endfunction

    // Line value of bit number idx within the frame carrying word w.
    function automatic logic exp_bit(input int d, input logic [8:0] w, input int idx);
        int wd;
        int pm;
        int ones;
        wd   = width_of(d);
        pm   = (d == 0) ? P_A : P_B;
        ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= wd) return w[idx-1];
        if (pm != 0 && idx == wd + 1) begin
            for (int i = 0; i < wd; i++) ones += int'(w[i]);
            return ((ones % 2) == 1) ^ (pm == 2);
        end
        return 1'b1;
    endfunction

    function automatic int msize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic mpush(input int d, input logic [8:0] w);
        if (msize(d) >= DEPTH) mov[d] = 1'b1;
        else if (d == 0) mq0.push_back(w);
        else mq1.push_back(w);
    endtask

    task automatic mpop(input int d, output logic [8:0] w);
        if (d == 0) w = mq0.pop_front();
        else w = mq1.pop_front();
    endtask

    task automatic model_reset;
        mq0.delete();
        mq1.delete();
        mov[0] = 1'b0;
        mov[1] = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int d, input logic [8:0] w);
        logic [8:0] m;
        m = w & 9'((1 << width_of(d)) - 1);
        data_in[d] = m;
        newdata[d] = 1'b1;
        tick();
        newdata[d] = 1'b0;
        mpush(d, m);
    endtask

    task automatic check_idle(input int d, input string name);
        checks++;
        if ({tx[d], busy[d], empty[d], level[d], overflow[d]} !==
            {1'b1, 1'b0, msize(d) == 0, 3'(msize(d)), mov[d]})
            $display("FAIL %s: dut%0d tx=%b busy=%b empty=%b level=%0d ovf=%b, want tx=1 busy=0 empty=%0d level=%0d ovf=%b",
                     name, d, tx[d], busy[d], empty[d], level[d], overflow[d], msize(d) == 0, msize(d), mov[d]);
        else passed++;
    endtask

    // Entered on the sample just after the pop edge; checks n frames cycle by cycle.
    task automatic check_stream(input int d, input int n, input int lock_at, input string name);
        int f;
        int bad;
        logic got;
        logic gotb;
        logic want;
        logic [8:0] w;
        f = frame_bits(d) * CPB;
        for (int i = 0; i < n; i++) begin
            bad = -1; got = 1'b0; gotb = 1'b0; want = 1'b0;
            mpop(d, w);
            checks++;
            if ({empty[d], level[d]} !== {msize(d) == 0, 3'(msize(d))})
                $display("FAIL %s level: dut%0d frame %0d empty=%b level=%0d, want empty=%0d level=%0d",
                         name, d, i, empty[d], level[d], msize(d) == 0, msize(d));
            else passed++;
            for (int j = 0; j < f; j++) begin
                if (bad < 0 && (tx[d] !== exp_bit(d, w, j / CPB) || busy[d] !== 1'b1)) begin
                    bad = j; got = tx[d]; gotb = busy[d]; want = exp_bit(d, w, j / CPB);
                end
                if (j == lock_at) lock[d] = 1'b1;
                tick();
            end
            checks++;
            if (bad >= 0)
                $display("FAIL %s frame: dut%0d frame %0d word %h cycle %0d tx=%b busy=%b, want tx=%b busy=1",
                         name, d, i, w, bad, got, gotb, want);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            newdata[d] = 1'b0; lock[d] = 1'b0; data_in[d] = '0;
        end
        model_reset();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({tx[d], busy[d], empty[d], full[d], level[d], overflow[d]} !== 8'b1_0_1_0_000_0)
                $display("FAIL reset: dut%0d tx/busy/empty/full/level/ovf=%b%b%b%b_%0d_%b, want 1010_0_0",
                         d, tx[d], busy[d], empty[d], full[d], level[d], overflow[d]);
            else passed++;
        end
        rst_n = 1'b1;
        tick();
        check_idle(0, "post reset");
        check_idle(1, "post reset");
    endtask

    task automatic test_single_frames;
        logic [8:0] w;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0) w = (d == 0) ? 9'h055 : 9'h1FF;
                else if (k == 1) w = (d == 0) ? 9'h0FF : 9'h007;
                else w = 9'($urandom);
                write_word(d, w);
                checks++;
                if ({tx[d], level[d]} !== {1'b1, 3'd1})
                    $display("FAIL write latency: dut%0d tx=%b level=%0d, want tx=1 level=1", d, tx[d], level[d]);
                else passed++;
                tick();
                check_stream(d, 1, -1, "single");
                check_idle(d, "single idle");
            end
        end
    endtask

    task automatic test_overflow;
        lock[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write_word(0, 9'($urandom));
            checks++;
            if ({full[0], level[0], overflow[0]} !== {msize(0) == DEPTH, 3'(msize(0)), mov[0]})
                $display("FAIL overflow write %0d: full=%b level=%0d ovf=%b, want full=%0d level=%0d ovf=%b",
                         i, full[0], level[0], overflow[0], msize(0) == DEPTH, msize(0), mov[0]);
            else passed++;
        end
        lock[0] = 1'b0;
        tick();
        check_stream(0, DEPTH, -1, "overflow drain");
        check_idle(0, "overflow idle");
    endtask

    task automatic test_lock_release;
        lock[0] = 1'b1;
        for (int i = 0; i < 3; i++) write_word(0, 9'($urandom));
        repeat (5) tick();
        check_idle(0, "locked queue");
        lock[0] = 1'b0;
        tick();
        check_stream(0, 3, -1, "lock release");
        check_idle(0, "lock release idle");
    endtask

    task automatic test_back_to_back;
        logic [8:0] w;
        lock[1] = 1'b1;
        write_word(1, 9'($urandom));
        write_word(1, 9'($urandom));
        w = 9'($urandom);
        data_in[1] = w;
        newdata[1] = 1'b1;
        lock[1] = 1'b0;
        tick();
        newdata[1] = 1'b0;
        mpush(1, w);
        check_stream(1, 3, -1, "back to back");
        check_idle(1, "back to back idle");
    endtask

    task automatic test_lock_midframe;
        write_word(0, 9'($urandom));
        write_word(0, 9'($urandom));
        check_stream(0, 1, 2 * CPB + 1, "lock midframe");
        check_idle(0, "lock held");
        repeat (7) tick();
        check_idle(0, "lock held later");
        lock[0] = 1'b0;
        tick();
        check_stream(0, 1, -1, "after unlock");
        check_idle(0, "after unlock idle");
    endtask

    task automatic test_reset_midframe;
        write_word(0, 9'($urandom));
        write_word(0, 9'($urandom));
        repeat (CPB * 4 + 2) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({tx[0], busy[0], empty[0], level[0], overflow[0]} !== 7'b1_0_1_000_0)
            $display("FAIL reset midframe: tx=%b busy=%b empty=%b level=%0d ovf=%b, want 1 0 1 0 0",
                     tx[0], busy[0], empty[0], level[0], overflow[0]);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle(0, "reset released");
        write_word(0, 9'h0A3);
        checks++;
        if ({tx[0], level[0]} !== {1'b1, 3'd1})
            $display("FAIL post reset write: tx=%b level=%0d, want tx=1 level=1", tx[0], level[0]);
        else passed++;
        tick();
        check_stream(0, 1, -1, "post reset frame");
        check_idle(0, "post reset frame idle");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frames();
        test_overflow();
        test_lock_release();
        test_back_to_back();
        test_lock_midframe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_PER_BIT, default 434; clocks per serial bit (50MHz/115200); legal range 2 or more.
REQ-002 SHALL have parameter DATAWIDTH_BUS, default 8; data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0; 0=none, 1=even, 2=odd.
REQ-004 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_ADDR, default 2; FIFO depth = 2^FIFO_ADDR entries.
REQ-006 SHALL have parameter STATE_SIZE, default 3; FSM state register width.
REQ-007 SHALL have port UART_TX_FIFO_CLOCK_50, in, 1; the single clock; all logic on its rising edge.
REQ-008 SHALL have port UART_TX_FIFO_RESET_InLow, in, 1; asynchronous, active-low reset.
REQ-009 SHALL have port UART_TX_FIFO_newData_InHigh, in, 1; write strobe, one word per high cycle.
REQ-010 SHALL have port UART_TX_FIFO_data_In, in, DATAWIDTH_BUS; write data.
REQ-011 SHALL have port UART_TX_FIFO_LOCK_InHigh, in, 1; while high, no new frame starts.
REQ-012 SHALL have port UART_TX_FIFO_tx_Out, out, 1; serial line, idle high, registered.
REQ-013 SHALL have port UART_TX_FIFO_busy_Out, out, 1; high while a frame is in progress.
REQ-014 SHALL have port UART_TX_FIFO_full_Out, out, 1; FIFO holds 2^FIFO_ADDR words.
REQ-015 SHALL have port UART_TX_FIFO_empty_Out, out, 1; FIFO holds 0 words.
REQ-016 SHALL have port UART_TX_FIFO_level_Out, out, FIFO_ADDR+1; current FIFO occupancy.
REQ-017 SHALL have port UART_TX_FIFO_overflow_Out, out, 1; sticky flag: a write was dropped.

Function
REQ-018 Write: newData high and full_Out low at edge k -> word stored at tail; level +1 after edge k.
REQ-019 Write while full_Out high (value before any same-cycle pop): word dropped, overflow_Out set after that edge; flag held until reset.
REQ-020 Simultaneous write and pop, not full: level unchanged; both take effect.
REQ-021 FIFO pointers: FIFO_ADDR bits, wrap modulo depth; full/empty derived from the level counter.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP; encoded in STATE_SIZE bits.
REQ-023 IDLE: tx_Out=1; if empty_Out low and LOCK low at edge k -> pop head into shift register, enter START; tx_Out=0 from edge k.
REQ-024 Bit timing: baud counter runs 0..CLOCK_PER_BIT-1; every bit period lasts exactly CLOCK_PER_BIT clocks.
REQ-025 START: one bit period, tx_Out=0; then DATA.
REQ-026 DATA: DATAWIDTH_BUS bit periods, LSB first; then PARITY if PARITY_MODE!=0, else STOP.
REQ-027 PARITY: one period; even mode sends XOR of data bits; odd mode sends its inverse.
REQ-028 STOP: STOP_BITS periods, tx_Out=1.
REQ-029 At end of STOP: if FIFO non-empty and LOCK low -> pop and enter START on the same edge (no idle gap); else IDLE.
REQ-030 Frame length SHALL be exactly (1+DATAWIDTH_BUS+(PARITY_MODE!=0)+STOP_BITS)*CLOCK_PER_BIT clocks.
REQ-031 LOCK rising mid-frame: current frame completes unchanged; FIFO retained; next frame waits for LOCK low.
REQ-032 busy_Out SHALL be high exactly when state != IDLE.
REQ-033 Write into empty FIFO at edge k, IDLE, LOCK low -> tx_Out low after edge k+1.
REQ-034 Illegal state codes SHALL return to IDLE on the next edge.

Reset
REQ-035 RESET_InLow low SHALL immediately force: tx_Out=1, busy_Out=0, empty_Out=1, full_Out=0, level_Out=0, overflow_Out=0, state=IDLE, baud counter=0.
REQ-036 Reset mid-frame SHALL abort the frame and discard FIFO contents; no partial frame resumes.
REQ-037 Reset deassertion: first frame start possible on the first edge after release plus one write.

Verification (CLOCK_PER_BIT=4 unless stated)
REQ-038 8N1, write 0x55 at edge k -> tx low after k+1; line 0,1,0,1,0,1,0,1,0,1 per 4-clock bit; busy low after 40 clocks.
REQ-039 PARITY_MODE=1, write 0x07 -> parity bit 1; PARITY_MODE=2, write 0x07 -> parity 0; frame 44 clocks.
REQ-040 Depth 4: write 6 words back-to-back while LOCK high -> full after 4th; words 5,6 dropped; overflow=1; level=4.
REQ-041 Release LOCK with 3 words queued -> 3 contiguous frames, no idle cycle between them; empty after 3rd pop.
REQ-042 Assert reset at mid DATA bit 3 -> tx_Out=1 same cycle; level 0; after release, write 0xA3 -> clean frame.
REQ-043 DATAWIDTH_BUS=9, STOP_BITS=2, write 0x1FF -> 9 ones, 2 stop bits; frame 48 clocks.
